// File: rtl/switch_debouncer_pkg.sv
// Shared types and defaults for the switch input conditioning stage.
package switch_debouncer_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_e;

  // 10 ms at the 100 MHz board clock.
  localparam int DEFAULT_STABLE_CYCLES = 1_000_000;

endpackage

// File: rtl/switch_debouncer_bit.sv
// One switch bit: two-flop synchroniser, stability counter, STABLE/PENDING FSM
// and registered rise/fall pulses coincident with the first cycle of a new level.
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic pending_o
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  state_e        state_q;
  logic          level_q;
  logic          rise_q;
  logic          fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= STABLE;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      case (state_q)
        STABLE: begin
          if (sync2_q != level_q) begin
            cnt_q   <= CW'(1);
            state_q <= PENDING;
          end else begin
            cnt_q   <= '0;
          end
        end
        PENDING: begin
          if (sync2_q == level_q) begin
            // Bounced back before acceptance: drop the candidate silently.
            cnt_q   <= '0;
            state_q <= STABLE;
          end else if (cnt_q == LAST_CNT) begin
            level_q <= sync2_q;
            rise_q  <= sync2_q;
            fall_q  <= ~sync2_q;
            cnt_q   <= '0;
            state_q <= STABLE;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign pending_o = (state_q == PENDING);

endmodule

// File: rtl/switch_debouncer.sv
// Synchronises and debounces WIDTH raw switch pins independently in the fast
// board clock domain; dbg_pending shows which bits are mid-debounce.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] switch_raw,
  output logic [WIDTH-1:0] switch_level,
  output logic [WIDTH-1:0] switch_rise,
  output logic [WIDTH-1:0] switch_fall,
  output logic [WIDTH-1:0] dbg_pending
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk_i    (clk),
      .rst_ni   (n_reset),
      .raw_i    (switch_raw[g]),
      .level_o  (switch_level[g]),
      .rise_o   (switch_rise[g]),
      .fall_o   (switch_fall[g]),
      .pending_o(dbg_pending[g])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with STABLE_CYCLES=4: directed vector table,
// hand-written reset corner cases and randomized holds against a reference model.
module tb_switch_debouncer;

  localparam int W  = 4;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic [W-1:0] switch_raw = '0;
  logic [W-1:0] switch_level, switch_rise, switch_fall, dbg_pending;

  int checks = 0;
  int failures = 0;

  switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .switch_raw  (switch_raw),
    .switch_level(switch_level),
    .switch_rise (switch_rise),
    .switch_fall (switch_fall),
    .dbg_pending (dbg_pending)
  );

  always #5 clk = ~clk;

  // Reference model: the level flips once the value seen two edges after
  // capture has differed from it on SC consecutive edges.
  logic [W-1:0] m_level, m_rise, m_fall;
  int           m_run[W];
  logic [W-1:0] m_hist[$];

  task automatic model_reset();
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
    for (int b = 0; b < W; b++) m_run[b] = 0;
    m_hist.delete();
    m_hist.push_back('0);
    m_hist.push_back('0);
  endtask

  task automatic model_step(input logic [W-1:0] r, input logic rst);
    logic [W-1:0] seen;
    if (!rst) begin
      model_reset();
    end else begin
      seen = m_hist.pop_front();
      m_hist.push_back(r);
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < W; b++) begin
        if (seen[b] != m_level[b]) begin
          m_run[b]++;
          if (m_run[b] == SC) begin
            m_level[b] = seen[b];
            if (seen[b]) m_rise[b] = 1'b1;
            else         m_fall[b] = 1'b1;
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got {level,rise,fall}=%h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: the model sees the inputs present at the edge, outputs are
  // compared 1 time unit after it.
  task automatic tick();
    logic [W-1:0] r;
    logic         rst;
    r   = switch_raw;
    rst = n_reset;
    @(posedge clk);
    model_step(r, rst);
    #1;
    check("model", {switch_level, switch_rise, switch_fall}, {m_level, m_rise, m_fall});
  endtask

  typedef struct {
    logic [W-1:0] raw;
    int           ticks;
    logic [W-1:0] lvl;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;

  vec_t vecs[$];

  initial begin
    model_reset();

    // Clean press/release on bit0 (from level 0).
    vecs.push_back('{4'h1, 5, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h1, 1, 4'h1, 4'h1, 4'h0});
    vecs.push_back('{4'h1, 1, 4'h1, 4'h0, 4'h0});
    vecs.push_back('{4'h0, 5, 4'h1, 4'h0, 4'h0});
    vecs.push_back('{4'h0, 1, 4'h0, 4'h0, 4'h1});
    vecs.push_back('{4'h0, 1, 4'h0, 4'h0, 4'h0});
    // Short glitch on bit2.
    vecs.push_back('{4'h4, 3, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{4'h0, 8, 4'h0, 4'h0, 4'h0});
    // Reach level 8, then bit0 rises while bit3 falls.
    vecs.push_back('{4'h8, 6, 4'h8, 4'h8, 4'h0});
    vecs.push_back('{4'h8, 2, 4'h8, 4'h0, 4'h0});
    vecs.push_back('{4'h1, 6, 4'h1, 4'h1, 4'h8});
    vecs.push_back('{4'h1, 1, 4'h1, 4'h0, 4'h0});
    // Bit1 bounces 1,0,1,0 every 2 cycles, then holds 1.
    vecs.push_back('{4'h3, 2, 4'h1, 4'h0, 4'h0});
    vecs.push_back('{4'h1, 2, 4'h1, 4'h0, 4'h0});
    vecs.push_back('{4'h3, 2, 4'h1, 4'h0, 4'h0});
    vecs.push_back('{4'h1, 2, 4'h1, 4'h0, 4'h0});
    vecs.push_back('{4'h3, 5, 4'h1, 4'h0, 4'h0});
    vecs.push_back('{4'h3, 1, 4'h3, 4'h2, 4'h0});
    vecs.push_back('{4'h3, 1, 4'h3, 4'h0, 4'h0});
    // Drop bit0 so it can be caught mid-count next.
    vecs.push_back('{4'h2, 8, 4'h2, 4'h0, 4'h0});

    // Reset hold with all pins high.
    switch_raw = 4'hF;
    #1;
    check("reset_async", {switch_level, switch_rise, switch_fall}, 12'h000);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("reset_hold", {switch_level, switch_rise, switch_fall}, 12'h000);
    end
    n_reset = 1'b1;
    repeat (5) tick();
    check("rst_rel_wait", {switch_level, switch_rise, switch_fall}, 12'h000);
    tick();
    check("rst_rel_rise", {switch_level, switch_rise, switch_fall}, 12'hFF0);
    tick();
    check("rst_rel_after", {switch_level, switch_rise, switch_fall}, 12'hF00);
    switch_raw = 4'h0;
    repeat (8) tick();
    check("settle_low", {switch_level, switch_rise, switch_fall}, 12'h000);

    for (int v = 0; v < vecs.size(); v++) begin
      switch_raw = vecs[v].raw;
      repeat (vecs[v].ticks) tick();
      check($sformatf("vec%0d", v), {switch_level, switch_rise, switch_fall},
            {vecs[v].lvl, vecs[v].rise, vecs[v].fall});
    end

    // Reset while bit0 is pending with counter at 2.
    switch_raw = 4'h3;
    repeat (4) tick();
    check("mid_pending", {switch_level, dbg_pending, 4'h0}, {4'h2, 4'h1, 4'h0});
    #2;
    n_reset = 1'b0;
    model_reset();
    #1;
    check("mid_rst_async", {switch_level, switch_rise, switch_fall}, 12'h000);
    check("mid_rst_dbg", {dbg_pending, 8'h00}, 12'h000);
    repeat (2) tick();
    n_reset = 1'b1;
    repeat (5) tick();
    check("post_rst_wait", {switch_level, switch_rise, switch_fall}, 12'h000);
    tick();
    check("post_rst_rise", {switch_level, switch_rise, switch_fall}, 12'h330);
    tick();
    check("post_rst_after", {switch_level, switch_rise, switch_fall}, 12'h300);

    // Randomized holds of 1..8 cycles against the model.
    for (int i = 0; i < 60; i++) begin
      switch_raw = W'($urandom_range(0, 15));
      repeat ($urandom_range(1, 8)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
